mem_port_arbiter: RTL and testbench

- Shares the single RAMHelper port between instruction fetch (IF) and the load/store unit (MEM).
- Converts byte addresses to RAMHelper doubleword indices.
- Generates write masks and aligns write data.
- Returns aligned responses and flags bad accesses.
- Sits between if_stage/LSU and the RAMHelper instance. Allows one outstanding transaction, with a one-cycle read turnaround.

---
 rtl/mem_port_arbiter_pkg.sv | 38 +++
 rtl/mem_lane_align.sv | 33 +++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the IF/MEM arbiter in front of the RAMHelper port.
package mem_port_arbiter_pkg;

   localparam logic [63:0] PC_START_DEF     = 64'h8000_0000;
   localparam logic [63:0] RAM_BYTES_DEF    = 64'h0800_0000;
   localparam int          STARVE_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_D = 2'd3
   } size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_MEM  = 2'd2
   } owner_e;

   // Byte enables of an access of the given size, before lane shifting.
   function automatic logic [7:0] size_be(input logic [1:0] size);
      logic [7:0] be;
      unique case (size_e'(size))
         SIZE_B:  be = 8'h01;
         SIZE_H:  be = 8'h03;
         SIZE_W:  be = 8'h0F;
         default: be = 8'hFF;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper: store mask/data placement, load data extraction, natural alignment check.
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [2:0]  wr_off_i,
   input  logic [63:0] wdata_i,
   input  logic [2:0]  rd_off_i,
   input  logic [63:0] rdata_i,
   output logic        misaligned_o,
   output logic [63:0] wmask_o,
   output logic [63:0] wdata_o,
   output logic [63:0] rdata_o
);

   logic [7:0] be;

   always_comb begin
      be = size_be(size_i) << wr_off_i;
      for (int i = 0; i < 8; i++) begin
         wmask_o[i*8 +: 8] = {8{be[i]}};
      end
      wdata_o = wdata_i << {wr_off_i, 3'b000};
      rdata_o = rdata_i >> {rd_off_i, 3'b000};
      unique case (size_e'(size_i))
         SIZE_B:  misaligned_o = 1'b0;
         SIZE_H:  misaligned_o = wr_off_i[0];
         SIZE_W:  misaligned_o = (wr_off_i[1:0] != 2'b00);
         default: misaligned_o = (wr_off_i != 3'b000);
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single RAMHelper port between instruction fetch and the LSU, one
// transaction in flight, response returned the cycle after the grant.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter logic [63:0] PC_START     = PC_START_DEF,
   parameter logic [63:0] RAM_BYTES    = RAM_BYTES_DEF,
   parameter int          STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   input  logic [63:0] if_req_addr,
   output logic        if_req_ready,
   input  logic        if_flush,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_inst,
   output logic        if_resp_err,
   input  logic        mem_req_valid,
   input  logic [63:0] mem_req_addr,
   input  logic        mem_req_wen,
   input  logic [1:0]  mem_req_size,
   input  logic [63:0] mem_req_wdata,
   output logic        mem_req_ready,
   output logic        mem_resp_valid,
   output logic [63:0] mem_resp_rdata,
   output logic        mem_resp_err,
   output logic        ram_en,
   output logic [63:0] ram_ridx,
   input  logic [63:0] ram_rdata,
   output logic [63:0] ram_widx,
   output logic [63:0] ram_wdata,
   output logic [63:0] ram_wmask,
   output logic        ram_wen
);

   localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   logic             err_q, err_d;
   logic             store_q, store_d;
   logic [2:0]       off_q, off_d;
   logic [CNT_W-1:0] starve_q, starve_d;

   logic [63:0] if_off, mem_off;
   logic        if_err, mem_err, mem_misal;
   logic        grant_if, grant_mem;
   logic [63:0] lane_wmask, lane_wdata, lane_rdata;

   // Lower bound is checked first, so the subtraction never relies on wrap.
   assign if_off  = if_req_addr - PC_START;
   assign mem_off = mem_req_addr - PC_START;
   assign if_err  = (if_req_addr[1:0] != 2'b00) || (if_req_addr < PC_START) || (if_off >= RAM_BYTES);
   assign mem_err = mem_misal || (mem_req_addr < PC_START) || (mem_off >= RAM_BYTES);

   mem_lane_align u_lane (
      .size_i       (mem_req_size),
      .wr_off_i     (mem_req_addr[2:0]),
      .wdata_i      (mem_req_wdata),
      .rd_off_i     (off_q),
      .rdata_i      (ram_rdata),
      .misaligned_o (mem_misal),
      .wmask_o      (lane_wmask),
      .wdata_o      (lane_wdata),
      .rdata_o      (lane_rdata)
   );

   always_comb begin
      // Reset level gates the grants so nothing leaves the block while rst is low.
      grant_mem = rst && mem_req_valid && !(if_req_valid && (starve_q == LIMIT));
      grant_if  = rst && if_req_valid && !grant_mem;

      ram_en    = 1'b0;
      ram_ridx  = '0;
      ram_wen   = 1'b0;
      ram_widx  = '0;
      ram_wdata = '0;
      ram_wmask = '0;
      state_d   = ST_IDLE;
      owner_d   = OWN_NONE;
      err_d     = 1'b0;
      store_d   = 1'b0;
      off_d     = 3'b000;
      starve_d  = starve_q;

      if (grant_mem) begin
         state_d = ST_RESP;
         owner_d = OWN_MEM;
         err_d   = mem_err;
         store_d = mem_req_wen;
         off_d   = mem_req_addr[2:0];
         if (!mem_err) begin
            ram_en   = 1'b1;
            ram_ridx = mem_off >> 3;
            if (mem_req_wen) begin
               ram_wen   = 1'b1;
               ram_widx  = mem_off >> 3;
               ram_wdata = lane_wdata;
               ram_wmask = lane_wmask;
            end
         end
      end else if (grant_if) begin
         state_d = ST_RESP;
         owner_d = OWN_IF;
         err_d   = if_err;
         off_d   = if_req_addr[2:0];
         if (!if_err) begin
            ram_en   = 1'b1;
            ram_ridx = if_off >> 3;
         end
      end

      if (grant_if || !if_req_valid) begin
         starve_d = '0;
      end else if (grant_mem && (starve_q != LIMIT)) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   assign if_req_ready  = grant_if;
   assign mem_req_ready = grant_mem;

   assign if_resp_valid  = (state_q == ST_RESP) && (owner_q == OWN_IF) && !if_flush;
   assign if_resp_err    = if_resp_valid && err_q;
   assign if_resp_inst   = (if_resp_valid && !err_q) ? (off_q[2] ? ram_rdata[63:32] : ram_rdata[31:0]) : 32'h0;
   assign mem_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_MEM);
   assign mem_resp_err   = mem_resp_valid && err_q;
   assign mem_resp_rdata = (mem_resp_valid && !err_q && !store_q) ? lane_rdata : 64'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_NONE;
         err_q    <= 1'b0;
         store_q  <= 1'b0;
         off_q    <= 3'b000;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         err_q    <= err_d;
         store_q  <= store_d;
         off_q    <= off_d;
         starve_q <= starve_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a byte-level memory model.
module tb_mem_port_arbiter;

   localparam logic [63:0] PCS  = 64'h8000_0000;
   localparam logic [63:0] RAMB = 64'h0800_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid, if_req_ready, if_flush, if_resp_valid, if_resp_err;
   logic [63:0] if_req_addr;
   logic [31:0] if_resp_inst;
   logic        mem_req_valid, mem_req_wen, mem_req_ready, mem_resp_valid, mem_resp_err;
   logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
   logic [1:0]  mem_req_size;
   logic        ram_en, ram_wen;
   logic [63:0] ram_ridx, ram_rdata, ram_widx, ram_wdata, ram_wmask;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  refmem [256];
   logic [63:0] ram    [32];

   int          streak;
   bit          pend_if, pend_mem, pend_err, pend_store;
   logic [63:0] pend_data;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
      .if_resp_err(if_resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
      .ram_en(ram_en), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata), .ram_widx(ram_widx),
      .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen)
   );

   // RAMHelper stand-in: registered read, masked write at the same edge.
   always @(posedge clk) begin
      if (ram_en) ram_rdata = ram[ram_ridx[4:0]];
      if (ram_wen) ram[ram_widx[4:0]] = (ram[ram_widx[4:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit in_range(input logic [63:0] a);
      return (a >= PCS) && (a < PCS + RAMB);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_if_ready"}, 64'(if_req_ready), 64'd0);
      check({tag, "_mem_ready"}, 64'(mem_req_ready), 64'd0);
      check({tag, "_if_resp_valid"}, 64'(if_resp_valid), 64'd0);
      check({tag, "_if_inst"}, 64'(if_resp_inst), 64'd0);
      check({tag, "_if_err"}, 64'(if_resp_err), 64'd0);
      check({tag, "_mem_resp_valid"}, 64'(mem_resp_valid), 64'd0);
      check({tag, "_mem_rdata"}, mem_resp_rdata, 64'd0);
      check({tag, "_mem_err"}, 64'(mem_resp_err), 64'd0);
      check({tag, "_ram_en"}, 64'(ram_en), 64'd0);
      check({tag, "_ram_wen"}, 64'(ram_wen), 64'd0);
      check({tag, "_ram_ridx"}, ram_ridx, 64'd0);
      check({tag, "_ram_widx"}, ram_widx, 64'd0);
      check({tag, "_ram_wdata"}, ram_wdata, 64'd0);
      check({tag, "_ram_wmask"}, ram_wmask, 64'd0);
   endtask

   // One clock of stimulus: predict, sample at the falling edge, advance the model.
   task automatic cycle();
      bit          gi, gm, ierr, merr, e_en, e_wen;
      int          nb, off, base;
      logic [63:0] a, e_mask, e_data;
      nb   = 1 << mem_req_size;
      gm   = mem_req_valid && !(if_req_valid && streak == 4);
      gi   = if_req_valid && !gm;
      ierr = (if_req_addr % 4 != 0) || !in_range(if_req_addr);
      merr = (mem_req_addr % nb != 0) || !in_range(mem_req_addr);
      a    = gm ? mem_req_addr : if_req_addr;
      e_en  = (gi && !ierr) || (gm && !merr);
      e_wen = gm && !merr && mem_req_wen;
      off   = int'(mem_req_addr % 8);
      e_mask = 64'd0;
      for (int b = 0; b < nb; b++) e_mask[(off + b) * 8 +: 8] = 8'hFF;
      e_data = mem_req_wdata << (8 * off);

      @(negedge clk);
      check("if_req_ready", 64'(if_req_ready), 64'(gi));
      check("mem_req_ready", 64'(mem_req_ready), 64'(gm));
      check("ram_en", 64'(ram_en), 64'(e_en));
      check("ram_wen", 64'(ram_wen), 64'(e_wen));
      if (e_en) check("ram_ridx", ram_ridx, (a - PCS) / 8);
      if (e_wen) begin
         check("ram_widx", ram_widx, (a - PCS) / 8);
         check("ram_wmask", ram_wmask, e_mask);
         check("ram_wdata", ram_wdata, e_data);
      end
      check("if_resp_valid", 64'(if_resp_valid), 64'(pend_if && !if_flush));
      if (pend_if && !if_flush) begin
         check("if_resp_err", 64'(if_resp_err), 64'(pend_err));
         check("if_resp_inst", 64'(if_resp_inst), pend_data);
      end
      check("mem_resp_valid", 64'(mem_resp_valid), 64'(pend_mem));
      if (pend_mem) begin
         check("mem_resp_err", 64'(mem_resp_err), 64'(pend_err));
         if (!pend_store || pend_err) check("mem_resp_rdata", mem_resp_rdata, pend_data);
      end

      pend_if    = gi;
      pend_mem   = gm;
      pend_err   = gi ? ierr : merr;
      pend_store = gm && mem_req_wen;
      pend_data  = 64'd0;
      if (gi && !ierr) begin
         base = int'(if_req_addr - PCS);
         for (int i = 0; i < 4; i++) pend_data[i*8 +: 8] = refmem[base + i];
      end else if (gm && !merr && !mem_req_wen) begin
         base = int'(mem_req_addr - PCS);
         for (int i = 0; i < 8 - off; i++) pend_data[i*8 +: 8] = refmem[base + i];
      end
      if (gi || !if_req_valid) streak = 0;
      else if (gm && streak < 4) streak++;
      if (e_wen) begin
         base = int'(mem_req_addr - PCS);
         for (int b = 0; b < nb; b++) refmem[base + b] = mem_req_wdata[b*8 +: 8];
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rand_addr(input int align);
      logic [63:0] a;
      if ($urandom_range(0, 9) == 0)
         a = ($urandom_range(0, 1) == 0) ? PCS - 64'($urandom_range(1, 32)) : PCS + RAMB + 64'($urandom_range(0, 32));
      else begin
         a = PCS + 64'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) a = a & ~64'(align - 1);
      end
      return a;
   endfunction

   task automatic idle_inputs();
      if_req_valid = 0; if_req_addr = 0; if_flush = 0;
      mem_req_valid = 0; mem_req_addr = 0; mem_req_wen = 0; mem_req_size = 0; mem_req_wdata = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ram[i] = {$urandom, $urandom};
      ram[0] = 64'h1111_2222_3333_4444;
      for (int i = 0; i < 256; i++) refmem[i] = ram[i / 8][(i % 8) * 8 +: 8];
      ram_rdata = 64'd0;
      streak = 0; pend_if = 0; pend_mem = 0; pend_err = 0; pend_store = 0; pend_data = 0;

      // Reset with both requesters asserting: nothing may escape.
      rst = 1'b0;
      idle_inputs();
      if_req_valid = 1; if_req_addr = PCS; mem_req_valid = 1; mem_req_addr = PCS + 8;
      mem_req_wen = 1; mem_req_size = 3; mem_req_wdata = 64'hFFFF;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Aligned fetch from the upper word of dword 0.
      if_req_valid = 1; if_req_addr = PCS + 4;
      cycle();
      idle_inputs();
      cycle();

      // Halfword store into lanes 2..3 of dword 1, then a load reading it back.
      mem_req_valid = 1; mem_req_addr = PCS + 64'hA; mem_req_wen = 1; mem_req_size = 1;
      mem_req_wdata = 64'hBEEF;
      cycle();
      mem_req_wen = 0; mem_req_size = 3; mem_req_addr = PCS + 8;
      cycle();
      idle_inputs();
      cycle();

      // Both requesters held valid: starvation guard must hand IF every fifth slot.
      for (int i = 0; i < 12; i++) begin
         if_req_valid = 1; if_req_addr = PCS + 64'(4 * $urandom_range(0, 63));
         mem_req_valid = 1; mem_req_wen = 0; mem_req_size = 3;
         mem_req_addr = PCS + 64'(8 * $urandom_range(0, 31));
         cycle();
      end
      idle_inputs();
      cycle();

      // Misaligned load and out-of-range fetch.
      mem_req_valid = 1; mem_req_addr = PCS + 2; mem_req_size = 2;
      cycle();
      idle_inputs();
      if_req_valid = 1; if_req_addr = 64'h7FFF_FFFC;
      cycle();
      idle_inputs();
      mem_req_valid = 1; mem_req_addr = PCS + 64'h11; mem_req_wen = 1; mem_req_size = 1;
      mem_req_wdata = 64'h1234;
      cycle();
      idle_inputs();
      cycle();

      // Redirect squashes the pending fetch response; the new fetch still goes through.
      if_req_valid = 1; if_req_addr = PCS + 64'h20;
      cycle();
      if_flush = 1; if_req_addr = PCS + 64'h24;
      cycle();
      idle_inputs();
      cycle();

      // Reset pulled in the response cycle of a load.
      mem_req_valid = 1; mem_req_addr = PCS + 64'h10; mem_req_size = 3;
      cycle();
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
      pend_if = 0; pend_mem = 0; streak = 0;
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      cycle();
      if_req_valid = 1; if_req_addr = PCS + 64'h30;
      cycle();
      idle_inputs();
      cycle();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         if_req_valid  = ($urandom_range(0, 3) != 0);
         if_req_addr   = rand_addr(4);
         if_flush      = ($urandom_range(0, 5) == 0);
         mem_req_valid = ($urandom_range(0, 2) != 0);
         mem_req_size  = 2'($urandom_range(0, 3));
         mem_req_addr  = rand_addr(1 << mem_req_size);
         mem_req_wen   = ($urandom_range(0, 1) == 1);
         mem_req_wdata = {$urandom, $urandom};
         cycle();
      end
      idle_inputs();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
